dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
Shares the single-port data memory between two requesters: the pipeline's MEM-stage load/store path (CPU port) and a debug/boot-load port (DBG port) that an external loader or monitor uses to inspect or fill memory.
The CPU port has priority, but a starvation counter guarantees the debug port a slot. When the debug port owns the memory, the arbiter stalls the pipeline. It sits between the LSU/pipeline registers and data_mem.

Parameters:
AW, 32, address width of both ports and memory
DW, 32, data width
MAX_WAIT, 8, maximum cycles a pending DBG request waits behind CPU traffic (legal range 1..255)

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset
cpu_req  input  1  CPU memory access this cycle (load or store)
cpu_we  input  1  1 = store, 0 = load
cpu_addr  input  AW  CPU byte address
cpu_wdata  input  DW  CPU store data
cpu_mask  input  4  CPU byte-lane mask
cpu_rdata  output  DW  load data to writeback mux
cpu_stall  output  1  hold pipeline (PC, IF/EX buffers) this cycle
dbg_req  input  1  debug access request, held until granted
dbg_we  input  1  1 = write, 0 = read
dbg_addr  input  AW  debug byte address, must be word aligned
dbg_wdata  input  DW  debug write data
dbg_gnt  output  1  debug access is being performed this cycle
dbg_rvalid  output  1  one-cycle pulse, dbg_rdata valid
dbg_rdata  output  DW  registered debug read data
dbg_err  output  1  one-cycle pulse, misaligned debug access rejected
mem_cs  output  1  memory select, active high
mem_rd  output  1  1 = read, 0 = write
mem_addr  output  AW  memory address
mem_wdata  output  DW  memory write data
mem_mask  output  4  memory byte-lane mask
mem_rdata  input  DW  memory read data, combinational from mem_addr

Behaviour:
- State machine has two states: S_CPU and S_DBG. Registers: state, wait_cnt[7:0], dbg_rdata, dbg_rvalid, dbg_err.
- Reset (reset=0, asynchronous): state=S_CPU, wait_cnt=0, dbg_rdata=0, dbg_rvalid=0, dbg_err=0. The resulting combinational outputs are cpu_stall=0 and dbg_gnt=0.
- In S_CPU, the memory is driven by the CPU:
  - mem_cs=cpu_req, mem_rd=~cpu_we, mem_addr/mem_wdata/mem_mask come from the cpu_* signals.
  - cpu_rdata=mem_rdata, giving zero added load latency.
  - cpu_stall=0 and dbg_gnt=0.
- Transition S_CPU→S_DBG when dbg_req && (!cpu_req || wait_cnt==MAX_WAIT-1).
- wait_cnt in S_CPU:
  - Increments (saturating at MAX_WAIT-1) when dbg_req && cpu_req and no transition occurs.
  - Clears when dbg_req=0.
- In S_DBG, the memory is driven by the debug port:
  - dbg_gnt=1 and cpu_stall=cpu_req; cpu_rdata=0.
  - mem_rd=~dbg_we, mem_addr=dbg_addr, mem_wdata=dbg_wdata, mem_mask=4'b1111.
  - mem_cs=1 if dbg_addr[1:0]==0, else mem_cs=0 (no access).
  - Exactly one access per grant. The next state is always S_CPU and wait_cnt clears. A back-to-back DBG request therefore restarts arbitration, and the CPU is never starved.
- Debug response:
  - On the clock edge leaving S_DBG with an aligned read, dbg_rdata is loaded with mem_rdata and dbg_rvalid=1 for one cycle.
  - An aligned write produces no rvalid; it is committed on that same edge by memory.
  - A misaligned access gives dbg_err=1 for one cycle, with no rvalid and no memory write.
  - dbg_rdata holds its value until the next debug read.
- Debug port rule: dbg_req and its dbg_* fields are held stable until the cycle dbg_gnt=1. The requester drops or changes them after that edge.
- The CPU sees the stall combinationally in the same cycle. The pipeline re-presents the identical cpu_* access next cycle, and the arbiter serves it in S_CPU.
- Simultaneous events:
  - cpu_req=0 with dbg_req=1 grants the debug port on the next cycle regardless of wait_cnt.
  - Both requests idle leaves the arbiter in S_CPU with mem_cs=0.
- MAX_WAIT=1 means a pending debug request is granted on the cycle after it appears, even under continuous CPU traffic.
- Reset asserted mid-S_DBG: the access is abandoned, with no rvalid/err pulse. A write in flight on the same edge as reset is undefined and the loader must retry.

Test Plan:
- Reset released, cpu_req=1 load addr 0x10, memory holds 0xDEADBEEF at 0x10 → cpu_rdata=0xDEADBEEF same cycle; cpu_stall=0; dbg_gnt=0.
- cpu_req=0, dbg_req=1 read 0x20 holding 0x12345678 → dbg_gnt=1 one cycle later, then dbg_rvalid=1 with dbg_rdata=0x12345678 for exactly one cycle.
- cpu_req held 1 continuously, dbg_req=1 write 0x40←0xA5A5A5A5, MAX_WAIT=8 → dbg_gnt asserts on the 8th cycle after dbg_req with cpu_stall=1 that cycle only; a subsequent CPU load of 0x40 returns 0xA5A5A5A5.
- dbg_req held 1 with new addresses each grant under full CPU traffic → dbg_gnt never in consecutive cycles, CPU served at least one cycle between grants.
- dbg_req=1 read 0x22 (misaligned) → dbg_gnt=1, mem_cs=0 that cycle, dbg_err pulse next cycle, no dbg_rvalid.
- Assert reset during S_DBG → state S_CPU immediately, dbg_gnt=0, cpu_stall=0, wait_cnt=0, no dbg_rvalid afterwards.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the CPU MEM stage and a debug/boot-load port.
// CPU has priority; a bounded wait counter guarantees the debug port one access slot.
module dmem_arbiter #(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int MAX_WAIT = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    input  logic [3:0]    cpu_mask,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_stall,
    input  logic          dbg_req,
    input  logic          dbg_we,
    input  logic [AW-1:0] dbg_addr,
    input  logic [DW-1:0] dbg_wdata,
    output logic          dbg_gnt,
    output logic          dbg_rvalid,
    output logic [DW-1:0] dbg_rdata,
    output logic          dbg_err,
    output logic          mem_cs,
    output logic          mem_rd,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic [3:0]    mem_mask,
    input  logic [DW-1:0] mem_rdata
);

    typedef enum logic {S_CPU = 1'b0, S_DBG = 1'b1} state_t;

    localparam logic [7:0] WAIT_LIM = 8'(MAX_WAIT - 1);

    state_t     state, state_nxt;
    logic [7:0] wait_cnt, wait_nxt;
    logic       dbg_aligned;

    assign dbg_aligned = (dbg_addr[1:0] == 2'b00);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_CPU;
            wait_cnt <= 8'd0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        wait_nxt  = wait_cnt;
        mem_cs    = cpu_req;
        mem_rd    = ~cpu_we;
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        mem_mask  = cpu_mask;
        cpu_rdata = mem_rdata;
        cpu_stall = 1'b0;
        dbg_gnt   = 1'b0;
        case (state)
            S_CPU: begin
                if (!dbg_req) begin
                    wait_nxt = 8'd0;
                end else if (!cpu_req || wait_cnt == WAIT_LIM) begin
                    state_nxt = S_DBG;
                    wait_nxt  = 8'd0;
                end else if (wait_cnt < WAIT_LIM) begin
                    wait_nxt = wait_cnt + 8'd1;
                end
            end
            S_DBG: begin
                // One access per grant; always hand the memory back so the CPU is never starved.
                dbg_gnt   = 1'b1;
                cpu_stall = cpu_req;
                cpu_rdata = '0;
                mem_cs    = dbg_aligned;
                mem_rd    = ~dbg_we;
                mem_addr  = dbg_addr;
                mem_wdata = dbg_wdata;
                mem_mask  = 4'b1111;
                state_nxt = S_CPU;
                wait_nxt  = 8'd0;
            end
            default: state_nxt = S_CPU;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dbg_rdata  <= '0;
            dbg_rvalid <= 1'b0;
            dbg_err    <= 1'b0;
        end else begin
            dbg_rvalid <= (state == S_DBG) && dbg_aligned && !dbg_we;
            dbg_err    <= (state == S_DBG) && !dbg_aligned;
            if (state == S_DBG && dbg_aligned && !dbg_we)
                dbg_rdata <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small behavioural word memory attached.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we;
    logic [31:0] cpu_addr, cpu_wdata;
    logic [3:0]  cpu_mask;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic        dbg_req, dbg_we;
    logic [31:0] dbg_addr, dbg_wdata;
    logic        dbg_gnt, dbg_rvalid, dbg_err;
    logic [31:0] dbg_rdata;
    logic        mem_cs, mem_rd;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_mask;

    logic [31:0] mem [0:255];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.AW(32), .DW(32), .MAX_WAIT(8)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_mask(cpu_mask), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata), .dbg_err(dbg_err),
        .mem_cs(mem_cs), .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_mask(mem_mask), .mem_rdata(mem_rdata)
    );

    assign mem_rdata = mem[mem_addr[9:2]];

    always @(posedge clk) begin
        if (mem_cs && !mem_rd)
            for (int b = 0; b < 4; b++)
                if (mem_mask[b]) mem[mem_addr[9:2]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    int gcyc, grants, consec, stalls;
    logic stall_g, stall_pre, prev_g, g;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[8'h04] = 32'hDEADBEEF;   // 0x10
        mem[8'h08] = 32'h12345678;   // 0x20
        mem[8'h09] = 32'h0BADF00D;   // 0x24
        mem[8'h0A] = 32'hCAFEF00D;   // 0x28
        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0; cpu_mask = 4'hF;
        dbg_req = 0; dbg_we = 0; dbg_addr = 0; dbg_wdata = 0;
        reset = 1'b1;
        #1 reset = 1'b0;
        #1;
        chk("rst_stall",  32'(cpu_stall),  32'd0);
        chk("rst_gnt",    32'(dbg_gnt),    32'd0);
        chk("rst_rvalid", 32'(dbg_rvalid), 32'd0);
        chk("rst_err",    32'(dbg_err),    32'd0);
        chk("rst_rdata",  dbg_rdata,       32'd0);
        cyc(); cyc();
        reset = 1'b1;

        // CPU load, zero latency
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10;
        #1;
        chk("cpu_load_data",  cpu_rdata,        32'hDEADBEEF);
        chk("cpu_load_stall", 32'(cpu_stall),   32'd0);
        chk("cpu_load_gnt",   32'(dbg_gnt),     32'd0);
        chk("cpu_load_cs",    32'(mem_cs),      32'd1);

        // Debug read with idle CPU
        cyc();
        cpu_req = 0; dbg_req = 1; dbg_we = 0; dbg_addr = 32'h20;
        #1;
        chk("dbgrd_gnt_c0", 32'(dbg_gnt), 32'd0);
        cyc();
        chk("dbgrd_gnt_c1", 32'(dbg_gnt),  32'd1);
        chk("dbgrd_cs",     32'(mem_cs),   32'd1);
        chk("dbgrd_addr",   mem_addr,      32'h20);
        chk("dbgrd_stall",  32'(cpu_stall), 32'd0);
        cyc();
        dbg_req = 0;
        #1;
        chk("dbgrd_rvalid", 32'(dbg_rvalid), 32'd1);
        chk("dbgrd_rdata",  dbg_rdata,       32'h12345678);
        chk("dbgrd_gnt_c2", 32'(dbg_gnt),    32'd0);
        cyc();
        chk("dbgrd_rvalid_off", 32'(dbg_rvalid), 32'd0);
        chk("dbgrd_rdata_hold", dbg_rdata,       32'h12345678);

        // Starvation bound: debug write under continuous CPU loads
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10;
        dbg_req = 1; dbg_we = 1; dbg_addr = 32'h40; dbg_wdata = 32'hA5A5A5A5;
        gcyc = -1; stall_g = 0; stall_pre = 1;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (i == 7) stall_pre = cpu_stall;
            if (dbg_gnt) begin
                gcyc = i; stall_g = cpu_stall;
                break;
            end
            cyc();
        end
        chk("starve_gnt_cycle", 32'(gcyc),      32'd8);
        chk("starve_stall_gnt", 32'(stall_g),   32'd1);
        chk("starve_stall_pre", 32'(stall_pre), 32'd0);
        chk("starve_mask",      32'(mem_mask),  32'hF);
        chk("starve_wr",        32'(mem_rd),    32'd0);
        cyc();
        dbg_req = 0;
        #1;
        chk("starve_gnt_after",   32'(dbg_gnt),    32'd0);
        chk("starve_stall_after", 32'(cpu_stall),  32'd0);
        chk("starve_no_rvalid",   32'(dbg_rvalid), 32'd0);
        cpu_addr = 32'h40;
        #1;
        chk("starve_cpu_readback", cpu_rdata, 32'hA5A5A5A5);

        // Held debug request: grants never back to back
        cyc();
        cpu_addr = 32'h10;
        dbg_req = 1; dbg_we = 0; dbg_addr = 32'h20;
        grants = 0; consec = 0; stalls = 0; prev_g = 0;
        for (int i = 0; i < 30; i++) begin
            #1;
            g = dbg_gnt;
            if (g) grants++;
            if (g && prev_g) consec++;
            if (cpu_stall) stalls++;
            prev_g = g;
            cyc();
            if (g) dbg_addr = dbg_addr + 32'd4;
        end
        dbg_req = 0;
        #1;
        chk("b2b_consec", 32'(consec), 32'd0);
        chk("b2b_grants", 32'(grants), 32'd3);
        chk("b2b_stalls", 32'(stalls), 32'd3);
        chk("b2b_rdata",  dbg_rdata,   32'hCAFEF00D);

        // Misaligned read
        cyc();
        cpu_req = 0; dbg_req = 1; dbg_we = 0; dbg_addr = 32'h22;
        cyc();
        chk("mis_rd_gnt", 32'(dbg_gnt), 32'd1);
        chk("mis_rd_cs",  32'(mem_cs),  32'd0);
        cyc();
        dbg_req = 0;
        #1;
        chk("mis_rd_err",    32'(dbg_err),    32'd1);
        chk("mis_rd_rvalid", 32'(dbg_rvalid), 32'd0);
        chk("mis_rd_rdata",  dbg_rdata,       32'hCAFEF00D);
        cyc();
        chk("mis_rd_err_off", 32'(dbg_err), 32'd0);

        // Misaligned write must not touch memory
        dbg_req = 1; dbg_we = 1; dbg_addr = 32'h13; dbg_wdata = 32'h0;
        cyc();
        chk("mis_wr_cs", 32'(mem_cs), 32'd0);
        cyc();
        dbg_req = 0; cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10;
        #1;
        chk("mis_wr_err",  32'(dbg_err), 32'd1);
        chk("mis_wr_keep", cpu_rdata,    32'hDEADBEEF);

        // Reset during a debug grant
        cyc();
        cpu_req = 0; dbg_req = 1; dbg_we = 0; dbg_addr = 32'h24;
        cyc();
        chk("rstdbg_gnt", 32'(dbg_gnt), 32'd1);
        cpu_req = 1;
        reset = 1'b0;
        #1;
        chk("rstdbg_gnt_off", 32'(dbg_gnt),   32'd0);
        chk("rstdbg_stall",   32'(cpu_stall), 32'd0);
        cyc();
        reset = 1'b1; dbg_req = 0;
        #1;
        chk("rstdbg_rvalid", 32'(dbg_rvalid), 32'd0);
        chk("rstdbg_err",    32'(dbg_err),    32'd0);
        chk("rstdbg_rdata",  dbg_rdata,       32'd0);
        cyc();
        chk("rstdbg_rvalid2", 32'(dbg_rvalid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
